// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
// Shared constants for the sequential arithmetic blocks: FSM state encoding
// for the divider and a helper that sizes iteration counters from the operand
// width.
// -----------------------------------------------------------------------------
package seq_div_pkg;

    // Operand width used when a divider is instantiated without overrides.
    localparam int DEFAULT_N_BITS = 15;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Width of a down-counter that must hold n_bits-1.
    // The result is at least one bit, so the counter stays legal at n_bits == 1.
    function automatic int cnt_width(input int n_bits);
        return (n_bits > 1) ? $clog2(n_bits) : 1;
    endfunction

endpackage

// File: rtl/seq_div_pos_sub.sv
// -----------------------------------------------------------------------------
// pos_sub
// Combinational unsigned compare-and-subtract. This is the subtract
// counterpart of pos_add.
//
// Ports
//   x      : minuend   (N bits, unsigned)
//   y      : subtrahend (N bits, unsigned)
//   diff   : x - y modulo 2**N
//   borrow : 1 when x < y. A value of 0 means x >= y and diff is exact.
// -----------------------------------------------------------------------------
module pos_sub #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] diff,
    output logic         borrow
);

    // Both results stay within N bits. No wider carry-out vector is built.
    assign diff   = x - y;
    assign borrow = (x < y);

endmodule

// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div
// Sequential unsigned restoring divider. The block produces one quotient bit
// per cycle, starting with the dividend MSB. A zero divisor skips the
// iteration. In that case the result is q = all ones, r = a, div_by_zero = 1.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : synchronous active-low reset
//   in_valid     : operand pair a/b presented
//   in_ready     : high only while idle; acceptance = in_valid && in_ready
//   a, b         : unsigned dividend / divisor (N_BITS)
//   out_valid    : high only while a result is held
//   out_ready    : consumer accepts the held result
//   q, r         : registered quotient / remainder (N_BITS)
//   div_by_zero  : result was produced from b == 0
// -----------------------------------------------------------------------------
module seq_div
    import seq_div_pkg::*;
#(
    parameter int N_BITS = DEFAULT_N_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] q,
    output logic [N_BITS-1:0] r,
    output logic              div_by_zero
);

    localparam int               CNT_W    = cnt_width(N_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

    div_state_e        state;
    div_state_e        state_next;

    logic [N_BITS-1:0] dvd_sh;     // latched dividend, shifted left one bit per step
    logic [N_BITS-1:0] dvs;        // latched divisor
    logic [N_BITS-1:0] quo;        // quotient, built LSB-in
    logic [N_BITS-1:0] rem;        // partial remainder
    logic              dbz;
    logic [CNT_W-1:0]  cnt;        // remaining steps after the current one

    logic [N_BITS:0]   part;       // P = {R, next dividend bit}
    logic [N_BITS:0]   diff;
    logic              borrow;
    logic              diff_msb_unused;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge only. rst_n is therefore just
    // another synchronous input, and it takes priority over every handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignment, so every flop sees the values from
            // before the edge no matter what order the statements run in.
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: the default is assigned first, so no path leaves state_next
        // unassigned and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)      state_next = (b == '0) ? DONE : CALC;
            CALC:    if (cnt == '0)     state_next = DONE;
            DONE:    if (out_ready)     state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // -------------------------------------------------------------------------
    // One restoring step: compare P against the divisor and subtract when it fits
    // -------------------------------------------------------------------------
    assign part = {rem, dvd_sh[N_BITS-1]};

    pos_sub #(
        .N (N_BITS + 1)
    ) u_pos_sub (
        .x      (part),
        .y      ({1'b0, dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

    // When there is no borrow, P < 2*b holds. P - b is then below b and fits
    // in N_BITS, so the top diff bit is always zero whenever it is selected.
    assign diff_msb_unused = diff[N_BITS];

    // -------------------------------------------------------------------------
    // Datapath registers. q/r come straight from flops, never from a/b.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_sh <= '0;
            dvs    <= '0;
            quo    <= '0;
            rem    <= '0;
            dbz    <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_sh <= a;
                        dvs    <= b;
                        if (b == '0) begin
                            quo <= '1;
                            rem <= a;
                            dbz <= 1'b1;
                        end else begin
                            quo <= '0;
                            rem <= '0;
                            dbz <= 1'b0;
                            cnt <= CNT_LAST;
                        end
                    end
                end
                CALC: begin
                    rem    <= borrow ? part[N_BITS-1:0] : diff[N_BITS-1:0];
                    quo    <= (quo << 1) | N_BITS'(!borrow);
                    dvd_sh <= dvd_sh << 1;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    // DONE: the result holds until the consumer takes it.
                end
            endcase
        end
    end

    assign q           = quo;
    assign r           = rem;
    assign div_by_zero = dbz;

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter N_BITS, default 15; bit width of dividend, divisor, quotient and remainder.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  N_BITS  unsigned dividend.
REQ-007 b  input  N_BITS  unsigned divisor.
REQ-008 out_valid  output  1  q/r/div_by_zero hold a valid result.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 q  output  N_BITS  quotient floor(a/b).
REQ-011 r  output  N_BITS  remainder a mod b.
REQ-012 div_by_zero  output  1  result produced from b==0.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC, DONE; reset state IDLE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Operands SHALL be accepted on a rising edge where in_valid && in_ready; a and b latched internally, later input changes ignored.
REQ-016 On acceptance with b!=0: next state CALC, iteration counter loaded with N_BITS-1, partial remainder cleared, div_by_zero cleared.
REQ-017 Each CALC cycle SHALL perform one restoring step, dividend bits MSB first: P = {R, next dividend bit} (N_BITS+1 bits); if P >= b then R = P - b and quotient bit = 1, else R = P and quotient bit = 0.
REQ-018 After exactly N_BITS CALC cycles the FSM SHALL enter DONE; out_valid is observed N_BITS cycles after the acceptance edge.
REQ-019 On acceptance with b==0: next state DONE directly (out_valid one cycle after acceptance edge), q = all ones, r = a, div_by_zero = 1.
REQ-020 For b!=0, q*b + r SHALL equal a and r < b; div_by_zero = 0.
REQ-021 In DONE, q, r, div_by_zero SHALL be held stable until out_ready is sampled 1; then FSM returns to IDLE (in_ready next cycle; no accept in the DONE-exit cycle).
REQ-022 out_ready sampled while not in DONE SHALL have no effect; in_valid sampled while not in IDLE SHALL be ignored (no queuing).
REQ-023 q and r SHALL be driven from registers; no combinational path from a/b to q/r.
REQ-024 All arithmetic unsigned; no intermediate SHALL exceed N_BITS+1 bits.

Reset
REQ-025 rst_n==0 at a rising edge SHALL force IDLE, in_ready=1 on the following cycle, out_valid=0, q=0, r=0, div_by_zero=0, counter=0.
REQ-026 Reset during CALC or DONE SHALL abort the operation; the pending result is discarded, never presented.
REQ-027 Reset SHALL take priority over a simultaneous in_valid/out_ready handshake.

Structure
REQ-028 FSM state encodings (IDLE=0, CALC=1, DONE=2, 2-bit) SHALL live in the shared package alongside other arithmetic-block constants.
REQ-029 The compare-and-subtract SHALL be one combinational sub-module pos_sub (#N parameter, inputs x/y, outputs diff and borrow), the subtract counterpart of pos_add; borrow==0 means P >= b.
REQ-030 Counter width SHALL be $clog2(N_BITS) bits minimum, derived from N_BITS.

Verification (N_BITS = 15)
REQ-031 a=100, b=7, out_ready=1 -> out_valid 15 cycles after acceptance; q=14, r=2, div_by_zero=0.
REQ-032 a=32767, b=1 -> q=32767, r=0; a=5, b=9 -> q=0, r=5.
REQ-033 a=1234, b=0 -> out_valid one cycle after acceptance; q=32767, r=1234, div_by_zero=1.
REQ-034 a=1000, b=3, out_ready held 0 for 10 cycles after out_valid -> q=333, r=1 stable throughout; in_valid pulses with new operands during CALC/DONE ignored; in_ready=1 cycle after out_ready=1.
REQ-035 rst_n=0 for one cycle at CALC cycle 7 of a=500, b=7 -> next cycle IDLE, all outputs 0, no out_valid; subsequent a=500, b=7 -> q=71, r=3.
REQ-036 Random self-check: 10k random a/b including b=0 and b>a, random out_ready stalls -> every result matches a/b reference model.
